decode_pipe: RTL and testbench
==============================

// Module: decode_pipe
// PURPOSE
//  Parametrised two-stage decode for the core: valid/ready in and out, GPR/FPR read-address drive,
//  a scoreboard of pending register writes, writeback bypass and flush. Sits between fetch
//  (in_*) and exec (out_*). Replaces the single-shot enable/done decode with a stallable pipeline.
// PARAMETERS
//  DATA_W  32  operand/immediate/data width
//  ADDR_W  29  jump address width
//  NREG    32  registers per file (GPR and FPR); RIDX = $clog2(NREG)
// PORTS
//  clk        in   1          clock
//  rstn       in   1          synchronous, active-low reset
//  flush      in   1          drop stage A and stage B contents
//  in_valid   in   1          instruction valid
//  in_ready   out  1          decode can accept
//  in_cmd     in   32         instruction: op=[31:26], s=[25:21], t=[20:16], d=[15:11], f=[10:6], funct=[5:0]
//  in_pc      in   ADDR_W     instruction address
//  rgreg1/2   out  RIDX       GPR read addresses; rfreg1/2 out RIDX = FPR read addresses
//  greg_out1/2, freg_out1/2  in DATA_W   combinational register-file read data
//  wb_valid   in   1          writeback this cycle; wb_rd in RIDX+1 ({isFPR,idx}); wb_data in DATA_W
//  out_valid  out  1          decoded bundle valid; out_ready in 1 = exec accepts
//  exec_command out 6 opcode; alu_command out 6 funct; addr out ADDR_W; rs, rt, data out DATA_W
//  wselector  out  2          00 none, 01 GPR result, 10 FPR result, 11 write `data`
//  rd         out  RIDX+1     destination {isFPR,idx}
// BEHAVIOUR
//  Reset: all valids, rgreg*, rfreg*, scoreboard and every out_* field 0; in_ready reads 1 once A is empty.
//  Stage A (hold cmd, pc): in_ready = !A_valid | A_adv. On accept, latch cmd/pc; register rgreg1=s, rgreg2=t,
//   rfreg1=d, rfreg2=t. Register-file data is valid while A holds.
//  Field decode by op:
//   0x00 R: rs=G[s], rt=G[t], rd={0,d}, wsel=01. 0x01 FPU: rs=F[d], rt=F[t], rd={1,f}, wsel=10.
//   0x02 j: addr=cmd[25:0] zero-extended, wsel=00. 0x03 jal: addr as j, rd={0,NREG-1}, data=pc+1, wsel=11.
//   Other I-type: rs=G[s], rt=G[t], data=sign-extended cmd[15:0], rd={0,t}, wsel=01.
//   exec_command=op; alu_command=funct. Sign/zero extension to DATA_W/ADDR_W; pc+1 wraps mod 2^ADDR_W.
//  Sources: only regs read per op. GPR 0 always reads 0, is never busy, and rd={0,0} never sets busy.
//  Hazard: src blocked if (busy[src] & !(wb_valid & wb_rd==src)) | (B_valid & B.wsel!=00 & B.rd==src).
//  A_adv = A_valid & !blocked & (!B_valid | out_ready). On A_adv, B latches decoded fields.
//  Operand = wb_data if wb_valid & wb_rd==src (same-cycle bypass), else the register-file read.
//  Stage B: out_valid=B_valid; fields stable while out_valid & !out_ready.
//   Fire = out_valid & out_ready: if wsel!=00, set busy[rd]. Latency: accept to out_valid = 2 cycles
//   when unblocked; back-to-back throughput 1/cycle with no hazards.
//  Scoreboard: wb_valid clears busy[wb_rd]; same reg set by fire and cleared by wb in one cycle -> set wins.
//  flush: next cycle A_valid=B_valid=0; in_ready=1; an in_valid in the flush cycle is dropped; scoreboard
//   is kept (in-flight writes still complete). flush has priority over accept/advance; reset over all.
//  Reset mid-operation: everything cleared; no output fire in the reset cycle.
// TESTING
//  1 addi r2 = op 0x08, s=1, t=2, imm 0xFFFF; G[1]=5 -> 2 cycles later out_valid, rs=5, data=0xFFFFFFFF, rd=2, wsel=01.
//  2 R writes r3; then R reads r3; no wb -> second holds in A, in_ready=0; wb r3=0x77 -> next out rs=0x77, busy[3]=0.
//  3 out_ready=0 for 5 cycles with 2 instructions queued -> B fields stable, in_ready=0; release -> 2 fires, 1/cycle.
//  4 jal, pc=0x1FFFFFFF -> data=0, rd={0,31}, wsel=11, addr=cmd[25:0]; then read r31 stalls until wb r31.
//  5 flush with A and B full -> next cycle out_valid=0, busy bits unchanged; new instruction 2 cycles later.
//  6 wb_valid to {1,4} in the cycle an FPU op sources F4 from A -> rs=wb_data; rstn=0 mid-stall -> all out 0, busy 0.

Source files
------------

// File: rtl/decode_pipe_if.sv
// rtl/decode_pipe_if.sv - fetch-side and exec-side handshake bundle for decode_pipe
interface decode_pipe_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 29,
   parameter int NREG   = 32
) ();
   localparam int RIDX = $clog2(NREG);

   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_cmd;
   logic [ADDR_W-1:0] in_pc;

   logic              out_valid;
   logic              out_ready;
   logic [5:0]        exec_command;
   logic [5:0]        alu_command;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] rs;
   logic [DATA_W-1:0] rt;
   logic [DATA_W-1:0] data;
   logic [1:0]        wselector;
   logic [RIDX:0]     rd;

   modport master (
      input  in_valid, in_cmd, in_pc, out_ready,
      output in_ready, out_valid, exec_command, alu_command, addr, rs, rt, data, wselector, rd
   );

   modport slave (
      output in_valid, in_cmd, in_pc, out_ready,
      input  in_ready, out_valid, exec_command, alu_command, addr, rs, rt, data, wselector, rd
   );
endinterface

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - two-stage stallable decode with register scoreboard, writeback bypass and flush
module decode_pipe #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 29,
   parameter int NREG   = 32
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    flush,
   decode_pipe_if.master           bus,
   output logic [$clog2(NREG)-1:0] rgreg1,
   output logic [$clog2(NREG)-1:0] rgreg2,
   output logic [$clog2(NREG)-1:0] rfreg1,
   output logic [$clog2(NREG)-1:0] rfreg2,
   input  logic [DATA_W-1:0]       greg_out1,
   input  logic [DATA_W-1:0]       greg_out2,
   input  logic [DATA_W-1:0]       freg_out1,
   input  logic [DATA_W-1:0]       freg_out2,
   input  logic                    wb_valid,
   input  logic [$clog2(NREG):0]   wb_rd,
   input  logic [DATA_W-1:0]       wb_data
);
   localparam int RIDX = $clog2(NREG);
   localparam int NSB  = 2 * NREG;
   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_FPU = 6'h01;
   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;

   logic              a_valid_q, a_valid_d;
   logic [31:0]       a_cmd_q, a_cmd_d;
   logic [ADDR_W-1:0] a_pc_q, a_pc_d;
   logic [RIDX-1:0]   rgreg1_q, rgreg1_d, rgreg2_q, rgreg2_d;
   logic [RIDX-1:0]   rfreg1_q, rfreg1_d, rfreg2_q, rfreg2_d;

   logic              b_valid_q, b_valid_d;
   logic [5:0]        b_exec_q, b_exec_d;
   logic [5:0]        b_alu_q, b_alu_d;
   logic [ADDR_W-1:0] b_addr_q, b_addr_d;
   logic [DATA_W-1:0] b_rs_q, b_rs_d;
   logic [DATA_W-1:0] b_rt_q, b_rt_d;
   logic [DATA_W-1:0] b_data_q, b_data_d;
   logic [1:0]        b_wsel_q, b_wsel_d;
   logic [RIDX:0]     b_rd_q, b_rd_d;

   // Indexed by {isFPR, idx}; bit 0 (GPR 0) is held at zero.
   logic [NSB-1:0]    busy_q, busy_d;

   logic [5:0]        op;
   logic [RIDX-1:0]   f_s, f_t, f_d, f_f;
   logic [ADDR_W-1:0] pc_inc;
   logic              src1_en, src2_en;
   logic [RIDX:0]     src1_id, src2_id;
   logic [DATA_W-1:0] dec_rs, dec_rt, dec_data;
   logic [ADDR_W-1:0] dec_addr;
   logic [RIDX:0]     dec_rd;
   logic [1:0]        dec_wsel;
   logic              haz1, haz2, a_adv, in_ready_w, accept, fire;

   function automatic logic [DATA_W-1:0] operand(
      input logic [RIDX:0]     id,
      input logic [DATA_W-1:0] rf_data,
      input logic              byp_v,
      input logic [RIDX:0]     byp_rd,
      input logic [DATA_W-1:0] byp_data
   );
      if (id == '0)
         return '0;
      else if (byp_v && byp_rd == id)
         return byp_data;
      else
         return rf_data;
   endfunction

   assign op     = a_cmd_q[31:26];
   assign f_s    = a_cmd_q[21 +: RIDX];
   assign f_t    = a_cmd_q[16 +: RIDX];
   assign f_d    = a_cmd_q[11 +: RIDX];
   assign f_f    = a_cmd_q[6 +: RIDX];
   assign pc_inc = a_pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

   always_comb begin
      src1_en  = 1'b0;
      src2_en  = 1'b0;
      src1_id  = '0;
      src2_id  = '0;
      dec_rs   = '0;
      dec_rt   = '0;
      dec_data = '0;
      dec_addr = '0;
      dec_rd   = '0;
      dec_wsel = 2'b00;
      case (op)
         OP_R: begin
            src1_en  = 1'b1;
            src2_en  = 1'b1;
            src1_id  = {1'b0, f_s};
            src2_id  = {1'b0, f_t};
            dec_rs   = operand(src1_id, greg_out1, wb_valid, wb_rd, wb_data);
            dec_rt   = operand(src2_id, greg_out2, wb_valid, wb_rd, wb_data);
            dec_rd   = {1'b0, f_d};
            dec_wsel = 2'b01;
         end
         OP_FPU: begin
            src1_en  = 1'b1;
            src2_en  = 1'b1;
            src1_id  = {1'b1, f_d};
            src2_id  = {1'b1, f_t};
            dec_rs   = operand(src1_id, freg_out1, wb_valid, wb_rd, wb_data);
            dec_rt   = operand(src2_id, freg_out2, wb_valid, wb_rd, wb_data);
            dec_rd   = {1'b1, f_f};
            dec_wsel = 2'b10;
         end
         OP_J: begin
            dec_addr = {{(ADDR_W-26){1'b0}}, a_cmd_q[25:0]};
         end
         OP_JAL: begin
            dec_addr = {{(ADDR_W-26){1'b0}}, a_cmd_q[25:0]};
            dec_rd   = {1'b0, RIDX'(NREG - 1)};
            dec_data = {{(DATA_W-ADDR_W){1'b0}}, pc_inc};
            dec_wsel = 2'b11;
         end
         default: begin
            src1_en  = 1'b1;
            src2_en  = 1'b1;
            src1_id  = {1'b0, f_s};
            src2_id  = {1'b0, f_t};
            dec_rs   = operand(src1_id, greg_out1, wb_valid, wb_rd, wb_data);
            dec_rt   = operand(src2_id, greg_out2, wb_valid, wb_rd, wb_data);
            dec_data = {{(DATA_W-16){a_cmd_q[15]}}, a_cmd_q[15:0]};
            dec_rd   = {1'b0, f_t};
            dec_wsel = 2'b01;
         end
      endcase
   end

   // A source waits on an unretired write, unless that write lands this cycle, or on the producer still in B.
   assign haz1 = src1_en && (src1_id != '0) &&
                 ((busy_q[src1_id] && !(wb_valid && wb_rd == src1_id)) ||
                  (b_valid_q && b_wsel_q != 2'b00 && b_rd_q == src1_id));
   assign haz2 = src2_en && (src2_id != '0) &&
                 ((busy_q[src2_id] && !(wb_valid && wb_rd == src2_id)) ||
                  (b_valid_q && b_wsel_q != 2'b00 && b_rd_q == src2_id));

   assign a_adv      = a_valid_q && !(haz1 || haz2) && (!b_valid_q || bus.out_ready);
   assign in_ready_w = !a_valid_q || a_adv;
   assign accept     = bus.in_valid && in_ready_w && !flush;
   assign fire       = b_valid_q && bus.out_ready;

   always_comb begin
      a_valid_d = a_valid_q;
      a_cmd_d   = a_cmd_q;
      a_pc_d    = a_pc_q;
      rgreg1_d  = rgreg1_q;
      rgreg2_d  = rgreg2_q;
      rfreg1_d  = rfreg1_q;
      rfreg2_d  = rfreg2_q;
      if (flush) begin
         a_valid_d = 1'b0;
      end else if (accept) begin
         a_valid_d = 1'b1;
         a_cmd_d   = bus.in_cmd;
         a_pc_d    = bus.in_pc;
         rgreg1_d  = bus.in_cmd[21 +: RIDX];
         rgreg2_d  = bus.in_cmd[16 +: RIDX];
         rfreg1_d  = bus.in_cmd[11 +: RIDX];
         rfreg2_d  = bus.in_cmd[16 +: RIDX];
      end else if (a_adv) begin
         a_valid_d = 1'b0;
      end
   end

   always_comb begin
      b_valid_d = b_valid_q;
      b_exec_d  = b_exec_q;
      b_alu_d   = b_alu_q;
      b_addr_d  = b_addr_q;
      b_rs_d    = b_rs_q;
      b_rt_d    = b_rt_q;
      b_data_d  = b_data_q;
      b_wsel_d  = b_wsel_q;
      b_rd_d    = b_rd_q;
      if (flush) begin
         b_valid_d = 1'b0;
      end else if (a_adv) begin
         b_valid_d = 1'b1;
         b_exec_d  = op;
         b_alu_d   = a_cmd_q[5:0];
         b_addr_d  = dec_addr;
         b_rs_d    = dec_rs;
         b_rt_d    = dec_rt;
         b_data_d  = dec_data;
         b_wsel_d  = dec_wsel;
         b_rd_d    = dec_rd;
      end else if (fire) begin
         b_valid_d = 1'b0;
      end
   end

   // A set from a fire is applied after the writeback clear so it wins on the same register.
   always_comb begin
      busy_d = busy_q;
      if (wb_valid)
         busy_d[wb_rd] = 1'b0;
      if (fire && b_wsel_q != 2'b00)
         busy_d[b_rd_q] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         a_valid_q <= 1'b0;
         a_cmd_q   <= '0;
         a_pc_q    <= '0;
         rgreg1_q  <= '0;
         rgreg2_q  <= '0;
         rfreg1_q  <= '0;
         rfreg2_q  <= '0;
         b_valid_q <= 1'b0;
         b_exec_q  <= '0;
         b_alu_q   <= '0;
         b_addr_q  <= '0;
         b_rs_q    <= '0;
         b_rt_q    <= '0;
         b_data_q  <= '0;
         b_wsel_q  <= '0;
         b_rd_q    <= '0;
         busy_q    <= '0;
      end else begin
         a_valid_q <= a_valid_d;
         a_cmd_q   <= a_cmd_d;
         a_pc_q    <= a_pc_d;
         rgreg1_q  <= rgreg1_d;
         rgreg2_q  <= rgreg2_d;
         rfreg1_q  <= rfreg1_d;
         rfreg2_q  <= rfreg2_d;
         b_valid_q <= b_valid_d;
         b_exec_q  <= b_exec_d;
         b_alu_q   <= b_alu_d;
         b_addr_q  <= b_addr_d;
         b_rs_q    <= b_rs_d;
         b_rt_q    <= b_rt_d;
         b_data_q  <= b_data_d;
         b_wsel_q  <= b_wsel_d;
         b_rd_q    <= b_rd_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.in_ready     = in_ready_w;
   assign bus.out_valid    = b_valid_q;
   assign bus.exec_command = b_exec_q;
   assign bus.alu_command  = b_alu_q;
   assign bus.addr         = b_addr_q;
   assign bus.rs           = b_rs_q;
   assign bus.rt           = b_rt_q;
   assign bus.data         = b_data_q;
   assign bus.wselector    = b_wsel_q;
   assign bus.rd           = b_rd_q;
   assign rgreg1           = rgreg1_q;
   assign rgreg2           = rgreg2_q;
   assign rfreg1           = rfreg1_q;
   assign rfreg2           = rfreg2_q;
endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - directed self-checking bench for decode_pipe
module tb_decode_pipe;
   logic        clk = 1'b0;
   logic        rstn, flush, wb_valid;
   logic [5:0]  wb_rd;
   logic [31:0] wb_data;
   logic [4:0]  rgreg1, rgreg2, rfreg1, rfreg2;
   logic [31:0] greg_out1, greg_out2, freg_out1, freg_out2;
   logic [31:0] gpr [32];
   logic [31:0] fpr [32];
   int checks = 0;
   int errors = 0;

   decode_pipe_if #(.DATA_W(32), .ADDR_W(29), .NREG(32)) bus ();

   decode_pipe #(.DATA_W(32), .ADDR_W(29), .NREG(32)) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .bus(bus),
      .rgreg1(rgreg1), .rgreg2(rgreg2), .rfreg1(rfreg1), .rfreg2(rfreg2),
      .greg_out1(greg_out1), .greg_out2(greg_out2), .freg_out1(freg_out1), .freg_out2(freg_out2),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   assign greg_out1 = gpr[rgreg1];
   assign greg_out2 = gpr[rgreg2];
   assign freg_out1 = fpr[rfreg1];
   assign freg_out2 = fpr[rfreg2];

   function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d, input logic [4:0] f, input logic [5:0] fn);
      return {op, s, t, d, f, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                         input logic [15:0] imm);
      return {op, s, t, imm};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_wb(input logic [5:0] r, input logic [31:0] v);
      cyc(); wb_valid = 1'b1; wb_rd = r; wb_data = v;
      cyc(); wb_valid = 1'b0;
   endtask

   task automatic test_reset();
      cyc(); cyc(); cyc(); #2;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %h exp 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %h exp 1", bus.in_ready); end
      checks++; if (bus.rd !== 6'h0 || bus.wselector !== 2'b00) begin errors++; $display("FAIL rst_rd_wsel got %h/%h exp 0/0", bus.rd, bus.wselector); end
      checks++; if (bus.rs !== 32'h0 || bus.data !== 32'h0) begin errors++; $display("FAIL rst_rs_data got %h/%h exp 0/0", bus.rs, bus.data); end
      checks++; if (rgreg1 !== 5'h0 || rfreg1 !== 5'h0) begin errors++; $display("FAIL rst_raddr got %h/%h exp 0/0", rgreg1, rfreg1); end
      checks++; if (dut.busy_q !== 64'h0) begin errors++; $display("FAIL rst_busy got %h exp 0", dut.busy_q); end
      cyc(); rstn = 1'b1;
   endtask

   task automatic test_addi();
      cyc(); bus.in_valid = 1'b1; bus.in_cmd = itype(6'h08, 5'd1, 5'd2, 16'hFFFF); bus.in_pc = 29'h100; #2;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready got %h exp 1", bus.in_ready); end
      cyc(); bus.in_valid = 1'b0; #2;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL addi_early_valid got %h exp 0", bus.out_valid); end
      checks++; if (rgreg1 !== 5'd1 || rgreg2 !== 5'd2 || rfreg1 !== 5'd31 || rfreg2 !== 5'd2) begin
         errors++; $display("FAIL addi_raddr got %h %h %h %h exp 01 02 1f 02", rgreg1, rgreg2, rfreg1, rfreg2); end
      cyc(); #2;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_out_valid got %h exp 1", bus.out_valid); end
      checks++; if (bus.rs !== 32'h5 || bus.rt !== 32'h22) begin errors++; $display("FAIL addi_rs_rt got %h/%h exp 5/22", bus.rs, bus.rt); end
      checks++; if (bus.data !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_data got %h exp ffffffff", bus.data); end
      checks++; if (bus.rd !== 6'd2 || bus.wselector !== 2'b01) begin errors++; $display("FAIL addi_rd_wsel got %h/%h exp 02/1", bus.rd, bus.wselector); end
      checks++; if (bus.exec_command !== 6'h08 || bus.alu_command !== 6'h3F) begin
         errors++; $display("FAIL addi_cmds got %h/%h exp 08/3f", bus.exec_command, bus.alu_command); end
      cyc(); #2;
      checks++; if (bus.out_valid !== 1'b0 || dut.busy_q[2] !== 1'b1) begin
         errors++; $display("FAIL addi_fire got valid %h busy2 %h exp 0/1", bus.out_valid, dut.busy_q[2]); end
      wb_valid = 1'b1; wb_rd = 6'd2; wb_data = 32'h1;
      cyc(); wb_valid = 1'b0; #2;
      checks++; if (dut.busy_q[2] !== 1'b0) begin errors++; $display("FAIL addi_wb_clear got %h exp 0", dut.busy_q[2]); end
   endtask

   task automatic test_hazard();
      cyc(); bus.in_valid = 1'b1; bus.in_cmd = rtype(6'h00, 5'd1, 5'd0, 5'd3, 5'd0, 6'h20);
      cyc(); bus.in_cmd = rtype(6'h00, 5'd3, 5'd1, 5'd4, 5'd0, 6'h20); #2;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL haz_second_accept got %h exp 1", bus.in_ready); end
      cyc(); bus.in_valid = 1'b0; #2;
      checks++; if (bus.out_valid !== 1'b1 || bus.rd !== 6'd3) begin errors++; $display("FAIL haz_first_out got %h/%h exp 1/03", bus.out_valid, bus.rd); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL haz_b_block got %h exp 0", bus.in_ready); end
      cyc(); #2;
      checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL haz_stall got ready %h valid %h exp 0/0", bus.in_ready, bus.out_valid); end
      checks++; if (dut.busy_q[3] !== 1'b1) begin errors++; $display("FAIL haz_busy3 got %h exp 1", dut.busy_q[3]); end
      cyc(); #2;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL haz_stall2 got %h exp 0", bus.in_ready); end
      cyc(); wb_valid = 1'b1; wb_rd = 6'd3; wb_data = 32'h77; #2;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL haz_wb_release got %h exp 1", bus.in_ready); end
      cyc(); wb_valid = 1'b0; #2;
      checks++; if (bus.out_valid !== 1'b1 || bus.rs !== 32'h77 || bus.rt !== 32'h5) begin
         errors++; $display("FAIL haz_bypass got valid %h rs %h rt %h exp 1/77/5", bus.out_valid, bus.rs, bus.rt); end
      checks++; if (bus.rd !== 6'd4 || dut.busy_q[3] !== 1'b0) begin
         errors++; $display("FAIL haz_rd_busy got rd %h busy3 %h exp 04/0", bus.rd, dut.busy_q[3]); end
      do_wb(6'd4, 32'h4);
   endtask

   task automatic test_backpressure();
      cyc(); bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_cmd = itype(6'h08, 5'd1, 5'd5, 16'h0001);
      cyc(); bus.in_cmd = itype(6'h08, 5'd1, 5'd6, 16'h0002);
      for (int i = 0; i < 5; i++) begin
         cyc(); bus.in_valid = 1'b0; #2;
         checks++; if (bus.out_valid !== 1'b1 || bus.rd !== 6'd5 || bus.data !== 32'h1 || bus.rs !== 32'h5) begin
            errors++; $display("FAIL bp_hold%0d got valid %h rd %h data %h rs %h exp 1/05/1/5", i, bus.out_valid, bus.rd, bus.data, bus.rs); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %h exp 0", i, bus.in_ready); end
      end
      cyc(); bus.out_ready = 1'b1; #2;
      checks++; if (bus.out_valid !== 1'b1 || bus.rd !== 6'd5 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release got valid %h rd %h ready %h exp 1/05/1", bus.out_valid, bus.rd, bus.in_ready); end
      cyc(); #2;
      checks++; if (bus.out_valid !== 1'b1 || bus.rd !== 6'd6 || bus.data !== 32'h2) begin
         errors++; $display("FAIL bp_second got valid %h rd %h data %h exp 1/06/2", bus.out_valid, bus.rd, bus.data); end
      cyc(); #2;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %h exp 0", bus.out_valid); end
      do_wb(6'd5, 32'h0);
      do_wb(6'd6, 32'h0);
   endtask

   task automatic test_jal();
      cyc(); bus.in_valid = 1'b1; bus.in_cmd = {6'h03, 26'h2ABCDEF}; bus.in_pc = 29'h1FFFFFFF;
      cyc(); bus.in_cmd = rtype(6'h00, 5'd31, 5'd0, 5'd7, 5'd0, 6'h20); bus.in_pc = 29'h0;
      cyc(); bus.in_valid = 1'b0; #2;
      checks++; if (bus.out_valid !== 1'b1 || bus.addr !== 29'h02ABCDEF) begin
         errors++; $display("FAIL jal_addr got valid %h addr %h exp 1/02abcdef", bus.out_valid, bus.addr); end
      checks++; if (bus.data !== 32'h0 || bus.rd !== 6'd31 || bus.wselector !== 2'b11) begin
         errors++; $display("FAIL jal_link got data %h rd %h wsel %h exp 0/1f/3", bus.data, bus.rd, bus.wselector); end
      checks++; if (bus.exec_command !== 6'h03 || bus.alu_command !== 6'h2F) begin
         errors++; $display("FAIL jal_cmds got %h/%h exp 03/2f", bus.exec_command, bus.alu_command); end
      for (int i = 0; i < 2; i++) begin
         cyc(); #2;
         checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL jal_r31_stall%0d got valid %h ready %h exp 0/0", i, bus.out_valid, bus.in_ready); end
      end
      cyc(); wb_valid = 1'b1; wb_rd = 6'd31; wb_data = 32'h1234;
      cyc(); wb_valid = 1'b0; #2;
      checks++; if (bus.out_valid !== 1'b1 || bus.rs !== 32'h1234 || bus.rd !== 6'd7) begin
         errors++; $display("FAIL jal_r31_read got valid %h rs %h rd %h exp 1/1234/07", bus.out_valid, bus.rs, bus.rd); end
   endtask

   task automatic test_flush();
      cyc(); bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_cmd = itype(6'h08, 5'd1, 5'd8, 16'h0003);
      cyc(); bus.in_cmd = itype(6'h08, 5'd1, 5'd9, 16'h0004);
      cyc(); flush = 1'b1; bus.in_cmd = itype(6'h08, 5'd1, 5'd12, 16'h0006); #2;
      checks++; if (bus.out_valid !== 1'b1 || bus.rd !== 6'd8) begin
         errors++; $display("FAIL fl_pre got valid %h rd %h exp 1/08", bus.out_valid, bus.rd); end
      cyc(); flush = 1'b0; bus.out_ready = 1'b1; bus.in_cmd = itype(6'h08, 5'd1, 5'd11, 16'h0005); #2;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL fl_empty got valid %h ready %h exp 0/1", bus.out_valid, bus.in_ready); end
      checks++; if (dut.busy_q !== 64'h80) begin errors++; $display("FAIL fl_busy_kept got %h exp 80", dut.busy_q); end
      cyc(); bus.in_valid = 1'b0; #2;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_latency got %h exp 0", bus.out_valid); end
      cyc(); #2;
      checks++; if (bus.out_valid !== 1'b1 || bus.rd !== 6'd11 || bus.data !== 32'h5) begin
         errors++; $display("FAIL fl_new got valid %h rd %h data %h exp 1/0b/5", bus.out_valid, bus.rd, bus.data); end
      do_wb(6'd11, 32'h0);
      do_wb(6'd7, 32'h0);
   endtask

   task automatic test_fpu_bypass_reset();
      cyc(); bus.in_valid = 1'b1; bus.in_cmd = rtype(6'h01, 5'd0, 5'd2, 5'd4, 5'd5, 6'h11);
      cyc(); bus.in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 6'h24; wb_data = 32'hABCD;
      cyc(); wb_valid = 1'b0; #2;
      checks++; if (bus.out_valid !== 1'b1 || bus.rs !== 32'hABCD || bus.rt !== 32'hF2) begin
         errors++; $display("FAIL fpu_bypass got valid %h rs %h rt %h exp 1/abcd/f2", bus.out_valid, bus.rs, bus.rt); end
      checks++; if (bus.rd !== 6'h25 || bus.wselector !== 2'b10 || bus.exec_command !== 6'h01) begin
         errors++; $display("FAIL fpu_fields got rd %h wsel %h op %h exp 25/2/01", bus.rd, bus.wselector, bus.exec_command); end
      cyc(); bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_cmd = itype(6'h08, 5'd1, 5'd10, 16'h0001); #2;
      checks++; if (dut.busy_q[37] !== 1'b1) begin errors++; $display("FAIL fpu_busy got %h exp 1", dut.busy_q[37]); end
      cyc(); bus.in_cmd = rtype(6'h01, 5'd0, 5'd2, 5'd5, 5'd6, 6'h11); #2;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fpu2_accept got %h exp 1", bus.in_ready); end
      cyc(); bus.in_valid = 1'b0; #2;
      checks++; if (bus.out_valid !== 1'b1 || bus.rd !== 6'd10 || bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL mid_stall got valid %h rd %h ready %h exp 1/0a/0", bus.out_valid, bus.rd, bus.in_ready); end
      cyc(); rstn = 1'b0; bus.out_ready = 1'b1; #2;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_sync got %h exp 1", bus.out_valid); end
      cyc(); #2;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_mid_valid got valid %h ready %h exp 0/1", bus.out_valid, bus.in_ready); end
      checks++; if (bus.rs !== 32'h0 || bus.rt !== 32'h0 || bus.data !== 32'h0 || bus.addr !== 29'h0) begin
         errors++; $display("FAIL rst_mid_data got %h %h %h %h exp all 0", bus.rs, bus.rt, bus.data, bus.addr); end
      checks++; if (bus.rd !== 6'h0 || bus.wselector !== 2'b00 || bus.exec_command !== 6'h0 || bus.alu_command !== 6'h0) begin
         errors++; $display("FAIL rst_mid_fields got %h %h %h %h exp all 0", bus.rd, bus.wselector, bus.exec_command, bus.alu_command); end
      checks++; if (rgreg1 !== 5'h0 || rgreg2 !== 5'h0 || rfreg1 !== 5'h0 || rfreg2 !== 5'h0) begin
         errors++; $display("FAIL rst_mid_raddr got %h %h %h %h exp all 0", rgreg1, rgreg2, rfreg1, rfreg2); end
      checks++; if (dut.busy_q !== 64'h0) begin errors++; $display("FAIL rst_mid_busy got %h exp 0", dut.busy_q); end
      cyc(); rstn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++) begin
         gpr[i] = 32'h1000 + i;
         fpr[i] = 32'h2000 + i;
      end
      gpr[0] = 32'h0; gpr[1] = 32'h5; gpr[2] = 32'h22; gpr[3] = 32'h33; gpr[31] = 32'h31;
      fpr[2] = 32'hF2; fpr[4] = 32'hF4;
      rstn = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
      bus.in_valid = 1'b0; bus.in_cmd = '0; bus.in_pc = '0; bus.out_ready = 1'b1;
      test_reset();
      test_addi();
      test_hazard();
      test_backpressure();
      test_jal();
      test_flush();
      test_fpu_bypass_reset();
      cyc(); cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
